// File: rtl/breath_pkg.sv
// rtl/breath_pkg.sv - shared state type and default timing for the breathing-LED sequencer
package breath_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE,
    S_HOLD_ON,
    S_FALL,
    S_HOLD_OFF
  } breath_state_t;

  localparam int DEF_CLK_DIV   = 100;
  localparam int DEF_PWM_STEPS = 1000;

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - prescaled PWM counter with registered compare output and frame strobe
module pwm_core
  import breath_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int PWM_STEPS = DEF_PWM_STEPS,
  parameter int DUTY_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              invert_i,
  output logic              led_o,
  output logic              fb_o
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              led_q, led_d;
  logic              tick;

  assign tick  = (presc_q == PRE_W'(CLK_DIV - 1));
  assign fb_o  = tick && (cnt_q == DUTY_W'(PWM_STEPS - 1));
  assign led_o = led_q;

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = fb_o ? '0 : cnt_q + DUTY_W'(1);
    end
    led_d = (cnt_q < duty_i) ^ invert_i;
    // A clear restarts the frame and drops the pin to its idle level at once.
    if (clr_i) begin
      presc_d = '0;
      cnt_d   = '0;
      led_d   = invert_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

endmodule

// File: rtl/breath_led_seq.sv
// rtl/breath_led_seq.sv - breathing envelope FSM stepping PWM duty on frame boundaries
module breath_led_seq
  import breath_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int PWM_STEPS = DEF_PWM_STEPS,
  parameter int DUTY_W    = 10,
  parameter int HOLD_W    = 8,
  parameter int REP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DUTY_W-1:0] cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold_on,
  input  logic [HOLD_W-1:0] cfg_hold_off,
  input  logic [REP_W-1:0]  cfg_repeat,
  input  logic              cfg_invert,
  output logic              led,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] duty
);

  localparam logic [DUTY_W:0] STEPS_X = (DUTY_W + 1)'(PWM_STEPS);

  breath_state_t     state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hon_q, hon_d, hoff_q, hoff_d;
  logic [REP_W-1:0]  cyc_q, cyc_d, rep_q, rep_d, cyc_inc;
  logic              inv_q, inv_d, done_q, done_d;
  logic              clr, fb;
  logic [DUTY_W:0]   sum;
  logic [HOLD_W:0]   hold_inc;

  pwm_core #(
    .CLK_DIV  (CLK_DIV),
    .PWM_STEPS(PWM_STEPS),
    .DUTY_W   (DUTY_W)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .duty_i  (duty_q),
    .invert_i(inv_q),
    .led_o   (led),
    .fb_o    (fb)
  );

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    step_d   = step_q;
    hold_d   = hold_q;
    hon_d    = hon_q;
    hoff_d   = hoff_q;
    cyc_d    = cyc_q;
    rep_d    = rep_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    clr      = 1'b0;
    sum      = {1'b0, duty_q} + {1'b0, step_q};
    hold_inc = {1'b0, hold_q} + (HOLD_W + 1)'(1);
    cyc_inc  = cyc_q + REP_W'(1);

    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      duty_d  = '0;
      clr     = 1'b1;
    end else if (state_q == S_IDLE) begin
      if (start && !stop) begin
        step_d  = (cfg_step == '0) ? DUTY_W'(1) : cfg_step;
        hon_d   = cfg_hold_on;
        hoff_d  = cfg_hold_off;
        rep_d   = cfg_repeat;
        inv_d   = cfg_invert;
        duty_d  = '0;
        hold_d  = '0;
        cyc_d   = '0;
        clr     = 1'b1;
        state_d = S_RISE;
      end
    end else if (fb) begin
      unique case (state_q)
        S_RISE: begin
          if (sum >= STEPS_X) begin
            duty_d  = DUTY_W'(PWM_STEPS);
            hold_d  = '0;
            state_d = S_HOLD_ON;
          end else begin
            duty_d = sum[DUTY_W-1:0];
          end
        end
        // Holds of 0 and 1 both dwell a single frame.
        S_HOLD_ON: begin
          if (hold_inc >= {1'b0, hon_q}) begin
            hold_d  = '0;
            state_d = S_FALL;
          end else begin
            hold_d = hold_inc[HOLD_W-1:0];
          end
        end
        S_FALL: begin
          if (duty_q <= step_q) begin
            duty_d  = '0;
            hold_d  = '0;
            state_d = S_HOLD_OFF;
          end else begin
            duty_d = duty_q - step_q;
          end
        end
        S_HOLD_OFF: begin
          if (hold_inc >= {1'b0, hoff_q}) begin
            hold_d = '0;
            cyc_d  = cyc_inc;
            if (rep_q != '0 && cyc_inc == rep_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RISE;
            end
          end else begin
            hold_d = hold_inc[HOLD_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      hon_q   <= '0;
      hoff_q  <= '0;
      cyc_q   <= '0;
      rep_q   <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      hon_q   <= hon_d;
      hoff_q  <= hoff_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign duty = duty_q;

endmodule

// File: tb/tb_breath_led_seq.sv
// tb/tb_breath_led_seq.sv - scoreboard bench: frame-level envelope model vs observed duty/led
module tb_breath_led_seq;

  localparam int CLK_DIV   = 2;
  localparam int PWM_STEPS = 8;
  localparam int DUTY_W    = 4;
  localparam int HOLD_W    = 8;
  localparam int REP_W     = 8;
  localparam int FRAME     = CLK_DIV * PWM_STEPS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [DUTY_W-1:0] cfg_step = '0;
  logic [HOLD_W-1:0] cfg_hold_on = '0;
  logic [HOLD_W-1:0] cfg_hold_off = '0;
  logic [REP_W-1:0]  cfg_repeat = '0;
  logic              cfg_invert = 1'b0;
  logic              led, busy, done;
  logic [DUTY_W-1:0] duty;

  breath_led_seq #(
    .CLK_DIV  (CLK_DIV),
    .PWM_STEPS(PWM_STEPS),
    .DUTY_W   (DUTY_W),
    .HOLD_W   (HOLD_W),
    .REP_W    (REP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_step    (cfg_step),
    .cfg_hold_on (cfg_hold_on),
    .cfg_hold_off(cfg_hold_off),
    .cfg_repeat  (cfg_repeat),
    .cfg_invert  (cfg_invert),
    .led         (led),
    .busy        (busy),
    .done        (done),
    .duty        (duty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
  endfunction

  typedef struct {
    bit is_end;
    int duty;
    int hi;
    bit done;
    bit led;
  } item_t;

  item_t exp_q[$];

  // Envelope as a list of per-frame duty values, straight from the breathing rules.
  function automatic void model_frames(input int step, input int hon, input int hoff,
                                       input int cycles, output int fr[$]);
    int s, d;
    s  = (step == 0) ? 1 : step;
    fr = {};
    for (int c = 0; c < cycles; c++) begin
      d = 0;
      do begin
        fr.push_back(d);
        d = (d + s > PWM_STEPS) ? PWM_STEPS : d + s;
      end while (d < PWM_STEPS);
      for (int h = 0; h < ((hon == 0) ? 1 : hon); h++) fr.push_back(PWM_STEPS);
      do begin
        fr.push_back(d);
        d = (d - s < 0) ? 0 : d - s;
      end while (d > 0);
      for (int h = 0; h < ((hoff == 0) ? 1 : hoff); h++) fr.push_back(0);
    end
  endfunction

  function automatic void push_expect(input int step, input int hon, input int hoff,
                                      input int cycles, input bit inv, input int limit);
    int    fr[$];
    item_t it;
    model_frames(step, hon, hoff, cycles, fr);
    for (int i = 0; i < fr.size() && i < limit; i++) begin
      it.is_end = 1'b0;
      it.duty   = fr[i];
      it.hi     = inv ? FRAME - fr[i] * CLK_DIV : fr[i] * CLK_DIV;
      it.done   = 1'b0;
      it.led    = 1'b0;
      exp_q.push_back(it);
    end
  endfunction

  function automatic void push_end(input bit dn, input bit ld);
    item_t it;
    it.is_end = 1'b1;
    it.duty   = 0;
    it.hi     = 0;
    it.done   = dn;
    it.led    = ld;
    exp_q.push_back(it);
  endfunction

  function automatic void sb_frame(input int d, input int hi);
    item_t it;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_frame", exp_q.size(), 1);
      return;
    end
    it = exp_q.pop_front();
    chk("sb_kind_frame", int'(it.is_end), 0);
    chk("frame_duty", d, it.duty);
    chk("frame_led_hi", hi, it.hi);
  endfunction

  function automatic void sb_end(input int dn, input int d, input int ld);
    item_t it;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_end", exp_q.size(), 1);
      return;
    end
    it = exp_q.pop_front();
    chk("sb_kind_end", int'(it.is_end), 1);
    chk("end_done", dn, int'(it.done));
    chk("end_duty", d, it.duty);
    chk("end_led", ld, int'(it.led));
  endfunction

  // Monitor: frames are counted from busy rising; led lags the compare by one cycle.
  logic busy_prev = 1'b0;
  int   phase = 0;
  int   hi_acc = 0;
  int   fr_duty = 0;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      phase   = 0;
      hi_acc  = 0;
      fr_duty = int'(duty);
    end else if (busy_prev) begin
      phase++;
      hi_acc += int'(led);
      if (phase == FRAME) begin
        sb_frame(fr_duty, hi_acc);
        phase   = 0;
        hi_acc  = 0;
        fr_duty = int'(duty);
      end
      if (!busy) sb_end(int'(done), int'(duty), int'(led));
    end
    if (done && !(busy_prev && !busy)) chk("done_outside_busy_fall", int'(done), 0);
    busy_prev = busy;
  end

  task automatic do_start(input int step, input int hon, input int hoff,
                          input int rep, input bit inv);
    @(negedge clk);
    cfg_step     = DUTY_W'(step);
    cfg_hold_on  = HOLD_W'(hon);
    cfg_hold_off = HOLD_W'(hoff);
    cfg_repeat   = REP_W'(rep);
    cfg_invert   = inv;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_duty(input int d, input int budget);
    int n;
    n = 0;
    while (int'(duty) != d && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("duty_wait_timeout", int'(duty), d);
  endtask

  initial begin
    int st, ho, hf, rp, bad, hi;
    bit iv;

    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_duty", int'(duty), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single cycle, then saturation, then step=0.
    push_expect(2, 1, 1, 1, 1'b0, 1000);
    push_end(1'b1, 1'b0);
    do_start(2, 1, 1, 1, 1'b0);
    chk("busy_after_start", int'(busy), 1);
    wait_idle(FRAME * 40);
    repeat (3) @(negedge clk);

    push_expect(3, 0, 0, 1, 1'b0, 1000);
    push_end(1'b1, 1'b0);
    do_start(3, 0, 0, 1, 1'b0);
    wait_idle(FRAME * 40);
    repeat (3) @(negedge clk);

    push_expect(0, 1, 2, 1, 1'b0, 1000);
    push_end(1'b1, 1'b0);
    do_start(0, 1, 2, 1, 1'b0);
    wait_idle(FRAME * 60);
    repeat (3) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      st = int'($urandom_range(0, 9));
      ho = int'($urandom_range(0, 3));
      hf = int'($urandom_range(0, 3));
      rp = int'($urandom_range(1, 2));
      iv = 1'($urandom_range(0, 1));
      push_expect(st, ho, hf, rp, iv, 1000);
      push_end(1'b1, iv);
      do_start(st, ho, hf, rp, iv);
      wait_idle(FRAME * 120);
      bad = 0;
      repeat (8) begin
        @(negedge clk);
        if (led != iv) bad++;
      end
      chk("idle_led_is_invert", bad, 0);
    end

    // stop mid-RISE at duty 4
    push_expect(2, 1, 1, 1, 1'b0, 2);
    push_end(1'b0, 1'b0);
    do_start(2, 1, 1, 1, 1'b0);
    wait_duty(4, FRAME * 10);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_duty", int'(duty), 0);
    chk("stop_led", int'(led), 0);
    chk("stop_done", int'(done), 0);
    repeat (3) @(negedge clk);

    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_busy", int'(busy), 0);
    @(negedge clk);
    chk("start_stop_busy_later", int'(busy), 0);

    // repeat=0: runs on, ignores cfg changes and a second start
    push_expect(2, 1, 1, 2, 1'b0, 1000);
    push_end(1'b0, 1'b0);
    do_start(2, 1, 1, 0, 1'b0);
    for (int i = 1; i <= 20 * FRAME; i++) begin
      @(negedge clk);
      if (i == 50) begin
        cfg_step     = 4'd5;
        cfg_hold_on  = 8'd0;
        cfg_hold_off = 8'd3;
        cfg_repeat   = 8'd1;
        cfg_invert   = 1'b1;
      end
      if (i == 100) start = 1'b1;
      if (i == 101) start = 1'b0;
    end
    chk("rep0_still_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("rep0_stopped", int'(busy), 0);
    repeat (3) @(negedge clk);

    // invert + async reset in HOLD_ON
    push_expect(4, 3, 0, 1, 1'b1, 3);
    push_end(1'b0, 1'b0);
    do_start(4, 3, 0, 1, 1'b1);
    wait_duty(8, FRAME * 10);
    hi = 0;
    repeat (FRAME) begin
      @(negedge clk);
      hi += int'(led);
    end
    chk("invert_full_duty_led_hi", hi, 0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(led), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_duty", int'(duty), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    repeat (FRAME) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/breath_led_seq.md
# breath_led_seq

Sequencer for the breathing-LED datapath. It owns a prescaled PWM counter and steps the PWM duty through a programmable envelope: rise, hold on, fall, hold off, repeated N times or forever. It sits between the board-level control logic (start/stop, config) and the LED pin, replacing free-running breathe logic with a started, stoppable and observable pattern. Frame-synchronous duty updates guarantee glitch-free brightness changes.

## Interface
- `CLK_DIV`, 100, clk cycles per PWM tick (2 µs at 50 MHz)
- `PWM_STEPS`, 1000, ticks per PWM frame; duty range 0..PWM_STEPS
- `DUTY_W`, 10, duty/step width; must hold PWM_STEPS
- `HOLD_W`, 8, hold-frame counter width
- `REP_W`, 8, repeat counter width
- `clk`  in  1  clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `start`  in  1  one-cycle pulse; begin a pattern (honoured only in IDLE)
- `stop`  in  1  one-cycle pulse; abort the pattern
- `cfg_step`  in  DUTY_W  duty increment/decrement per frame; 0 treated as 1
- `cfg_hold_on`  in  HOLD_W  frames held at full duty
- `cfg_hold_off`  in  HOLD_W  frames held at zero duty
- `cfg_repeat`  in  REP_W  breath cycles; 0 = run until stop
- `cfg_invert`  in  1  active-low LED polarity
- `led`  out  1  PWM output
- `busy`  out  1  high while not IDLE
- `done`  out  1  one-cycle pulse on normal completion
- `duty`  out  DUTY_W  current duty register

## Operation
- States: IDLE, RISE, HOLD_ON, FALL, HOLD_OFF.
- IDLE + start: latch all cfg_* into shadow registers; clear the prescaler, PWM counter, hold counter and cycle counter; set duty=0; go to RISE. cfg_* are ignored until the next IDLE start.
- Frame boundary (fb): the prescaler is at CLK_DIV-1 and the PWM counter is at PWM_STEPS-1. Duty and state change only on fb, except for start, stop and reset.
- RISE, on fb: duty = min(duty+step, PWM_STEPS), computed one bit wider, no wrap. If the result is PWM_STEPS, go to HOLD_ON with hold counter 0.
- HOLD_ON, on fb: increment the hold counter. When the count reaches cfg_hold_on, go to FALL. A value of 0 leaves after one frame, so the minimum dwell is one frame.
- FALL, on fb: duty = max(duty-step, 0), saturating. If the result is 0, go to HOLD_OFF.
- HOLD_OFF: same counting rule as HOLD_ON, using cfg_hold_off. At exit, increment the cycle counter. If cfg_repeat≠0 and the count equals cfg_repeat, go to IDLE and pulse done. Otherwise go to RISE.
- stop in any non-IDLE state: next cycle state=IDLE, duty=0, no done pulse. stop in IDLE has no effect.
- start and stop in the same cycle: stop wins, and the block stays or returns to IDLE.
- start while busy: ignored.
- led = (pwm_cnt < duty) XOR invert_shadow. Duty 0 gives constant off; duty PWM_STEPS gives constant on.
- Cycle counter width is REP_W. With cfg_repeat=0 it wraps freely.

## Timing
- Reset values: led=0, busy=0, done=0, duty=0, state IDLE, all counters 0, shadow cfg 0.
- start at cycle t: busy=1 at t+1, and the first PWM frame begins at t+1.
- The first duty update, to step, occurs on the fb at the end of frame 1.
- led is registered and lags the (pwm_cnt, duty) compare by 1 cycle.
- done is high for exactly 1 cycle, the same cycle busy falls.
- Reset mid-pattern: all outputs return to reset values asynchronously.
- In IDLE, the prescaler and PWM counter keep running, and led = invert_shadow (constant).

## Structure
- Shared package `breath_pkg`: state enum `breath_state_t`, default CLK_DIV/PWM_STEPS constants.
- Sub-module `pwm_core`: prescaler, PWM counter, registered compare output, fb strobe. Inputs: clr, duty, invert.
- Top level: FSM, saturating duty arithmetic, hold and cycle counters, shadow registers.

## Test plan
Bench parameters: CLK_DIV=2, PWM_STEPS=8, DUTY_W=4.
- Single cycle: reset; start with step=2, hold_on=1, hold_off=1, repeat=1.
  - duty per frame: 2, 4, 6, 8 (HOLD_ON), 8, 6, 4, 2, 0 (HOLD_OFF).
  - Then done pulses once and busy falls the same cycle.
  - led high-count per frame equals duty.
- Saturation: step=3 → duty 3, 6, 8 (clamped), then 5, 2, 0 (clamped), with no wrap.
- step=0: behaves identically to step=1, with duty 1..8.
- stop mid-RISE at duty=4: next cycle busy=0, duty=0, led=0, and done stays 0.
  - start and stop in the same cycle from IDLE: busy stays 0.
- repeat=0 with a cfg change while busy:
  - The pattern runs more than 300 cycles without done.
  - The changed cfg is not applied.
  - A second start while busy is ignored.
- Invert plus async reset mid-HOLD_ON:
  - With invert=1, duty=8 gives led constant 0.
  - rst_n low gives led=0, busy=0, duty=0 immediately.
